cache_assoc: RTL and testbench
==============================

CACHE_ASSOC -- requirements
Module: cache_assoc

Interface
REQ-001 SHALL have parameters: LineIndexBitWidth, 1, log2 of set count.
REQ-002 SHALL have parameters: RamAddressBitWidth, 4, burst RAM address width in 64-bit words.
REQ-003 SHALL have parameters: BurstDataCount, 4, 64-bit words per burst; line size = BurstDataCount*8 bytes.
REQ-004 SHALL have ports: clk input 1, single clock; rst_n input 1, asynchronous active-low reset.
REQ-005 SHALL have ports: enable input 1; address input 32, byte address; write_enable input 4, byte lanes, 0 = read; data_in input 32; data_out output 32; data_out_ready output 1; busy output 1.
REQ-006 SHALL have ports: br_cmd output 1 (0 read, 1 write); br_cmd_en output 1; br_addr output RamAddressBitWidth; br_wr_data output 64; br_data_mask output 8; br_rd_data input 64; br_rd_data_valid input 1.

Function
REQ-007 SHALL be 2-way set-associative, write-back, write-allocate, with per-line valid and dirty bits and a 1-bit LRU per set.
REQ-008 SHALL decode address as: [1:0] byte, next log2(BurstDataCount*2) bits column, next LineIndexBitWidth bits set, remaining bits up to RamAddressBitWidth+3 tag.
REQ-009 SHALL accept a request only when enable=1 and busy=0; requests while busy SHALL be ignored.
REQ-010 SHALL, on read hit, drive data_out and data_out_ready=1 the next cycle; busy stays 0.
REQ-011 SHALL, on write hit, merge data_in bytes selected by write_enable, set dirty, and raise no busy; data_out_ready=0 for writes.
REQ-012 SHALL, on miss, pick victim as first invalid way (way 0 first), else LRU way; busy=1 from the next cycle until completion.
REQ-013 SHALL run FSM IDLE -> WB_DATA (victim dirty) -> RD_CMD -> RD_DATA -> IDLE; clean victim skips WB_DATA.
REQ-014 SHALL, in WB_DATA, assert br_cmd=1 and br_cmd_en=1 for exactly one cycle with br_addr = victim line base; br_wr_data SHALL carry the line words in ascending order on BurstDataCount consecutive cycles starting that cycle.
REQ-015 SHALL, in RD_CMD, assert br_cmd=0 and br_cmd_en=1 for one cycle with br_addr = missed line base, then capture BurstDataCount words on br_rd_data_valid cycles in ascending order.
REQ-016 SHALL, on last fill word, set valid, clear dirty, write tag, then complete the pending request as a hit: read -> data_out_ready=1 and busy=0 the following cycle; write -> merge, dirty=1, busy=0.
REQ-017 SHALL mark the accessed way MRU on every hit and fill.
REQ-018 SHALL drive br_data_mask=0 constantly.
REQ-019 SHALL ignore br_rd_data_valid outside RD_DATA.
REQ-020 SHALL deassert data_out_ready in any cycle without a completing read.

Reset
REQ-021 SHALL, while rst_n=0, force busy=0, data_out_ready=0, data_out=0, br_cmd=0, br_cmd_en=0, FSM=IDLE, all valid, dirty and LRU bits=0.
REQ-022 SHALL abandon any in-flight burst on reset; dirty data is lost, no further br_cmd_en issued.

Configuration
REQ-023 SHALL, with CACHE_ASSOC_STATS_EN defined, add outputs hit_count and miss_count (32 bits each, reset 0, +1 per accepted hit/miss, wrap at 2^32).
REQ-024 SHALL, without CACHE_ASSOC_STATS_EN, omit those ports and counters; all other behaviour identical.

Verification (RamAddressBitWidth=6; each word at byte address A preloaded with A)
REQ-025 SHALL pass: cold read 0x10 -> one read burst br_addr=0x0, data_out=0x00000010; then read 0x0C -> data_out=0x0000000C, ready next cycle, busy 0.
REQ-026 SHALL pass: write 0x08 data_in=0xAD we=0001 then read 0x08 -> 0x000000AD; write 0xFEEF0000 we=1100 then read -> 0xFEEF00AD.
REQ-027 SHALL pass: read 0x00, 0x40 (both resident, no write-back), read 0x00, read 0x80 -> evicts 0x40 way; read 0x00 hits, read 0x40 misses.
REQ-028 SHALL pass: write 0x40=0x1B2D3F42, read 0x00, read 0x80 -> write burst br_cmd=1 br_addr=0x8 with 4 data words, then read 0x40 -> 0x1B2D3F42.
REQ-029 SHALL pass: rst_n low during RD_DATA -> busy=0, br_cmd_en=0 immediately; read 0x10 afterwards misses and returns 0x00000010.
REQ-030 SHALL pass with CACHE_ASSOC_STATS_EN: sequence of REQ-025 -> hit_count=1, miss_count=1.

Source files
------------

// File: rtl/cache_assoc.sv
`default_nettype none
// =============================================================================
// Module      : cache_assoc
// Description : 2-way set-associative write-back/write-allocate cache with a
//               64-bit burst RAM port. Define CACHE_ASSOC_STATS_EN to add
//               hit_count/miss_count outputs.
// Revision    : 1.0 - initial release
// =============================================================================
module cache_assoc #(
  parameter int LineIndexBitWidth  = 1,
  parameter int RamAddressBitWidth = 4,
  parameter int BurstDataCount     = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [31:0]                   address,
  input  logic [3:0]                    write_enable,
  input  logic [31:0]                   data_in,
  output logic [31:0]                   data_out,
  output logic                          data_out_ready,
  output logic                          busy,
  output logic                          br_cmd,
  output logic                          br_cmd_en,
  output logic [RamAddressBitWidth-1:0] br_addr,
  output logic [63:0]                   br_wr_data,
  output logic [7:0]                    br_data_mask,
  input  logic [63:0]                   br_rd_data,
  input  logic                          br_rd_data_valid
`ifdef CACHE_ASSOC_STATS_EN
  ,
  output logic [31:0]                   hit_count,
  output logic [31:0]                   miss_count
`endif
);

  localparam int WORDS  = BurstDataCount * 2;
  localparam int COL_W  = $clog2(WORDS);
  localparam int SETS   = 1 << LineIndexBitWidth;
  localparam int SET_LO = 2 + COL_W;
  localparam int TAG_LO = SET_LO + LineIndexBitWidth;
  localparam int TAG_HI = RamAddressBitWidth + 2;
  localparam int TAG_W  = TAG_HI - TAG_LO + 1;
  localparam int BEAT_W = $clog2(BurstDataCount);
  localparam int CNT_W  = BEAT_W + 1;

  typedef enum logic [1:0] {IDLE, WB_DATA, RD_CMD, RD_DATA} state_t;

  state_t                                 r_state;
  logic [31:0]                            r_data_mem [2][SETS][WORDS];
  logic [1:0][SETS-1:0][TAG_W-1:0]        r_tag_mem;
  logic [SETS-1:0][1:0]                   r_valid;
  logic [SETS-1:0][1:0]                   r_dirty;
  logic [SETS-1:0]                        r_lru;
  logic [CNT_W-1:0]                       r_cnt;
  logic [TAG_W-1:0]                       r_req_tag;
  logic [LineIndexBitWidth-1:0]           r_req_set;
  logic [COL_W-1:0]                       r_req_col;
  logic [3:0]                             r_req_we;
  logic [31:0]                            r_req_data;
  logic                                   r_req_way;

  logic [COL_W-1:0]                       w_col;
  logic [LineIndexBitWidth-1:0]           w_set;
  logic [TAG_W-1:0]                       w_tag;
  logic                                   w_hit0, w_hit1, w_hit, w_hit_way;
  logic                                   w_accept, w_victim, w_victim_dirty;
  logic                                   w_last;
  logic                                   w_wb_way;
  logic [LineIndexBitWidth-1:0]           w_wb_set;
  logic [BEAT_W-1:0]                      w_wb_beat;
  logic [63:0]                            w_wb_word;
  logic [31:0]                            w_fill_word;
  logic                                   unused_addr;

  assign w_col   = address[SET_LO-1:2];
  assign w_set   = address[TAG_LO-1:SET_LO];
  assign w_tag   = address[TAG_HI:TAG_LO];
  assign unused_addr = ^address[31:TAG_HI+1];

  assign w_hit0    = r_valid[w_set][0] && (r_tag_mem[0][w_set] == w_tag);
  assign w_hit1    = r_valid[w_set][1] && (r_tag_mem[1][w_set] == w_tag);
  assign w_hit     = w_hit0 | w_hit1;
  assign w_hit_way = w_hit1;
  assign w_accept  = enable && !busy;

  // Prefer an empty way (way 0 first); otherwise evict the LRU way.
  assign w_victim = !r_valid[w_set][0] ? 1'b0 :
                    !r_valid[w_set][1] ? 1'b1 : r_lru[w_set];
  assign w_victim_dirty = r_valid[w_set][w_victim] && r_dirty[w_set][w_victim];

  assign w_last = (r_state == RD_DATA) && br_rd_data_valid &&
                  (r_cnt == CNT_W'(BurstDataCount - 1));

  assign br_data_mask = 8'h00;

  function automatic logic [31:0] merge(input logic [31:0] old_w,
                                        input logic [31:0] new_w,
                                        input logic [3:0]  we);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (we[i]) res[i*8 +: 8] = new_w[i*8 +: 8];
    end
    return res;
  endfunction

  // Write-back word source: in IDLE the burst is being launched for the
  // victim of the incoming request, afterwards for the latched victim.
  always_comb begin
    if (r_state == IDLE) begin
      w_wb_way  = w_victim;
      w_wb_set  = w_set;
      w_wb_beat = '0;
    end else begin
      w_wb_way  = r_req_way;
      w_wb_set  = r_req_set;
      w_wb_beat = r_cnt[BEAT_W-1:0];
    end
    w_wb_word = {r_data_mem[w_wb_way][w_wb_set][{w_wb_beat, 1'b1}],
                 r_data_mem[w_wb_way][w_wb_set][{w_wb_beat, 1'b0}]};
  end

  // Requested word at fill completion; the last beat is not yet in the array.
  always_comb begin
    if (r_req_col[COL_W-1:1] == r_cnt[BEAT_W-1:0])
      w_fill_word = r_req_col[0] ? br_rd_data[63:32] : br_rd_data[31:0];
    else
      w_fill_word = r_data_mem[r_req_way][r_req_set][r_req_col];
  end

  always_ff @(posedge clk) begin
    if (r_state == IDLE && w_accept && w_hit && write_enable != 4'b0000)
      r_data_mem[w_hit_way][w_set][w_col] <=
        merge(r_data_mem[w_hit_way][w_set][w_col], data_in, write_enable);
    if (r_state == RD_DATA && br_rd_data_valid) begin
      r_data_mem[r_req_way][r_req_set][{r_cnt[BEAT_W-1:0], 1'b0}] <= br_rd_data[31:0];
      r_data_mem[r_req_way][r_req_set][{r_cnt[BEAT_W-1:0], 1'b1}] <= br_rd_data[63:32];
      if (w_last && r_req_we != 4'b0000)
        r_data_mem[r_req_way][r_req_set][r_req_col] <=
          merge(w_fill_word, r_req_data, r_req_we);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      busy           <= 1'b0;
      data_out_ready <= 1'b0;
      data_out       <= '0;
      br_cmd         <= 1'b0;
      br_cmd_en      <= 1'b0;
      br_addr        <= '0;
      br_wr_data     <= '0;
      r_tag_mem      <= '0;
      r_valid        <= '0;
      r_dirty        <= '0;
      r_lru          <= '0;
      r_cnt          <= '0;
      r_req_tag      <= '0;
      r_req_set      <= '0;
      r_req_col      <= '0;
      r_req_we       <= '0;
      r_req_data     <= '0;
      r_req_way      <= 1'b0;
    end else begin
      data_out_ready <= 1'b0;
      br_cmd_en      <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_hit) begin
              r_lru[w_set] <= ~w_hit_way;
              if (write_enable == 4'b0000) begin
                data_out       <= r_data_mem[w_hit_way][w_set][w_col];
                data_out_ready <= 1'b1;
              end else begin
                r_dirty[w_set][w_hit_way] <= 1'b1;
              end
            end else begin
              r_req_tag  <= w_tag;
              r_req_set  <= w_set;
              r_req_col  <= w_col;
              r_req_we   <= write_enable;
              r_req_data <= data_in;
              r_req_way  <= w_victim;
              busy       <= 1'b1;
              br_cmd_en  <= 1'b1;
              if (w_victim_dirty) begin
                r_state    <= WB_DATA;
                br_cmd     <= 1'b1;
                br_addr    <= {r_tag_mem[w_victim][w_set], w_set, {BEAT_W{1'b0}}};
                br_wr_data <= w_wb_word;
                r_cnt      <= CNT_W'(1);
              end else begin
                r_state <= RD_CMD;
                br_cmd  <= 1'b0;
                br_addr <= {w_tag, w_set, {BEAT_W{1'b0}}};
                r_cnt   <= '0;
              end
            end
          end
        end
        WB_DATA: begin
          if (r_cnt == CNT_W'(BurstDataCount)) begin
            r_state   <= RD_CMD;
            br_cmd    <= 1'b0;
            br_cmd_en <= 1'b1;
            br_addr   <= {r_req_tag, r_req_set, {BEAT_W{1'b0}}};
            r_cnt     <= '0;
            r_dirty[r_req_set][r_req_way] <= 1'b0;
          end else begin
            br_wr_data <= w_wb_word;
            r_cnt      <= r_cnt + 1'b1;
          end
        end
        RD_CMD: r_state <= RD_DATA;
        RD_DATA: begin
          if (br_rd_data_valid) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_state                       <= IDLE;
              busy                          <= 1'b0;
              r_cnt                         <= '0;
              r_valid[r_req_set][r_req_way] <= 1'b1;
              r_dirty[r_req_set][r_req_way] <= (r_req_we != 4'b0000);
              r_tag_mem[r_req_way][r_req_set] <= r_req_tag;
              r_lru[r_req_set]              <= ~r_req_way;
              if (r_req_we == 4'b0000) begin
                data_out       <= w_fill_word;
                data_out_ready <= 1'b1;
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef CACHE_ASSOC_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (w_accept) begin
      if (w_hit) hit_count  <= hit_count + 32'd1;
      else       miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_assoc.sv
`default_nettype none
// =============================================================================
// Module      : tb_cache_assoc
// Description : Randomized self-checking bench for cache_assoc against a
//               flat-memory / recency-list reference model.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_cache_assoc;
  localparam int RAW   = 6;
  localparam int BDC   = 4;
  localparam int SETS  = 2;
  localparam int LINEB = BDC * 8;
  localparam int NWORD = (1 << (RAW + 3)) / 4;
  localparam int NLINE = (1 << (RAW + 3)) / LINEB;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] address = '0;
  logic [3:0]  write_enable = '0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic        data_out_ready, busy, br_cmd, br_cmd_en;
  logic [RAW-1:0] br_addr;
  logic [63:0] br_wr_data;
  logic [7:0]  br_data_mask;
  logic [63:0] br_rd_data = '0;
  logic        br_rd_data_valid = 1'b0;
`ifdef CACHE_ASSOC_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  cache_assoc #(.LineIndexBitWidth(1), .RamAddressBitWidth(RAW), .BurstDataCount(BDC)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .address(address),
    .write_enable(write_enable), .data_in(data_in), .data_out(data_out),
    .data_out_ready(data_out_ready), .busy(busy), .br_cmd(br_cmd),
    .br_cmd_en(br_cmd_en), .br_addr(br_addr), .br_wr_data(br_wr_data),
    .br_data_mask(br_data_mask), .br_rd_data(br_rd_data),
    .br_rd_data_valid(br_rd_data_valid)
`ifdef CACHE_ASSOC_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference model: architectural memory view, backing store, recency lists.
  logic [31:0] cur [NWORD];
  logic [31:0] bk  [NWORD];
  int          res [SETS][$];
  bit          ldirty [NLINE];
  int          exp_b[$];
  int          got_b[$];
  int          nh = 0, nm = 0;

  logic [63:0] ram [1 << RAW];

  task automatic model_reset();
    for (int i = 0; i < NWORD; i++) cur[i] = bk[i];
    for (int s = 0; s < SETS; s++) res[s].delete();
    for (int l = 0; l < NLINE; l++) ldirty[l] = 1'b0;
    exp_b.delete();
    got_b.delete();
    nh = 0;
    nm = 0;
  endtask

  task automatic model_access(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d,
                              output bit hit, output logic [31:0] rd);
    int line, set, pos, v;
    line = int'(a) / LINEB;
    set  = line % SETS;
    pos  = -1;
    foreach (res[set][i]) if (res[set][i] == line) pos = i;
    if (pos >= 0) begin
      hit = 1'b1;
      res[set].delete(pos);
      res[set].push_front(line);
      nh++;
    end else begin
      hit = 1'b0;
      nm++;
      if (res[set].size() == 2) begin
        v = res[set].pop_back();
        if (ldirty[v]) begin
          exp_b.push_back((1 << 16) | (v * BDC));
          for (int k = 0; k < LINEB / 4; k++) bk[v * LINEB / 4 + k] = cur[v * LINEB / 4 + k];
          ldirty[v] = 1'b0;
        end
      end
      exp_b.push_back(line * BDC);
      res[set].push_front(line);
      ldirty[line] = 1'b0;
    end
    if (we != 4'b0000) begin
      for (int b = 0; b < 4; b++) if (we[b]) cur[a / 4][b*8 +: 8] = d[b*8 +: 8];
      ldirty[line] = 1'b1;
    end
    rd = cur[a / 4];
  endtask

  // Burst RAM responder; occasionally raises a stray valid when no read is due.
  int rd_left = 0, rd_idx = 0, wr_left = 0, wr_idx = 0;
  int rd_base = 0, wr_base = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rd_left = 0;
        wr_left = 0;
        br_rd_data_valid = 1'b0;
      end else begin
        br_rd_data_valid = 1'b0;
        if (rd_left > 0) begin
          if ($urandom_range(0, 2) != 0) begin
            br_rd_data = ram[rd_base + rd_idx];
            br_rd_data_valid = 1'b1;
            rd_idx++;
            rd_left--;
          end
        end else if ($urandom_range(0, 3) == 0) begin
          br_rd_data = {$urandom, $urandom};
          br_rd_data_valid = 1'b1;
        end
        if (br_cmd_en) begin
          got_b.push_back((int'(br_cmd) << 16) | int'(br_addr));
          if (br_cmd) begin wr_base = int'(br_addr); wr_idx = 0; wr_left = BDC; end
          else        begin rd_base = int'(br_addr); rd_idx = 0; rd_left = BDC; end
        end
        if (wr_left > 0) begin
          ram[wr_base + wr_idx] = br_wr_data;
          wr_idx++;
          wr_left--;
        end
      end
    end
  end

  task automatic apply_reset();
    rst_n = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_ready", data_out_ready, 0);
    check("rst_data", data_out, 0);
    check("rst_cmd", br_cmd, 0);
    check("rst_cmd_en", br_cmd_en, 0);
    check("rst_mask", br_data_mask, 0);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic access(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d,
                        output bit obs_hit, output logic [31:0] obs_data);
    bit          h;
    logic [31:0] exp;
    int          n;
    model_access(a, we, d, h, exp);
    @(negedge clk);
    enable = 1'b1; address = a; write_enable = we; data_in = d;
    @(posedge clk); #1;
    enable = 1'b0;
    obs_hit = !busy;
    if (h) begin
      check("hit_busy", busy, 0);
      check("hit_ready", data_out_ready, (we == 4'b0000));
      if (we == 4'b0000) check("hit_data", data_out, exp);
    end else begin
      check("miss_busy", busy, 1);
      // A request while busy must be ignored.
      @(negedge clk);
      enable = 1'b1; address = 32'($urandom_range(0, NWORD - 1) * 4);
      write_enable = 4'hF; data_in = 32'hDEAD0000 | 32'($urandom_range(0, 65535));
      @(posedge clk); #1;
      enable = 1'b0;
      n = 0;
      while (busy && n < 200) begin @(posedge clk); #1; n++; end
      check("miss_done", busy, 0);
      check("miss_ready", data_out_ready, (we == 4'b0000));
      if (we == 4'b0000) check("miss_data", data_out, exp);
    end
    obs_data = data_out;
    check("burst_count", got_b.size(), exp_b.size());
    for (int i = 0; i < exp_b.size(); i++)
      if (i < got_b.size()) check("burst", got_b[i], exp_b[i]);
    got_b.delete();
    exp_b.delete();
    @(posedge clk); #1;
    check("ready_drop", data_out_ready, 0);
  endtask

  initial begin
    bit          h;
    logic [31:0] r;
    int          n;
    for (int i = 0; i < NWORD; i++) bk[i] = 32'(i * 4);
    for (int i = 0; i < (1 << RAW); i++) ram[i] = {32'(i * 8 + 4), 32'(i * 8)};

    apply_reset();
    access(32'h10, 4'b0000, 0, h, r);
    check("c25_miss", h, 0);
    check("c25_data", r, 32'h10);
    access(32'h0C, 4'b0000, 0, h, r);
    check("c25_hit", h, 1);
    check("c25_data2", r, 32'h0C);
`ifdef CACHE_ASSOC_STATS_EN
    check("stat_hit", hit_count, 1);
    check("stat_miss", miss_count, 1);
`endif

    access(32'h08, 4'b0001, 32'hAD, h, r);
    access(32'h08, 4'b0000, 0, h, r);
    check("c26_rd1", r, 32'h000000AD);
    access(32'h08, 4'b1100, 32'hFEEF0000, h, r);
    access(32'h08, 4'b0000, 0, h, r);
    check("c26_rd2", r, 32'hFEEF00AD);

    apply_reset();
    access(32'h00, 4'b0000, 0, h, r);
    access(32'h40, 4'b0000, 0, h, r);
    access(32'h00, 4'b0000, 0, h, r);
    check("c27_hit00", h, 1);
    access(32'h80, 4'b0000, 0, h, r);
    check("c27_miss80", h, 0);
    access(32'h00, 4'b0000, 0, h, r);
    check("c27_hit00b", h, 1);
    access(32'h40, 4'b0000, 0, h, r);
    check("c27_miss40", h, 0);

    apply_reset();
    access(32'h40, 4'b1111, 32'h1B2D3F42, h, r);
    access(32'h00, 4'b0000, 0, h, r);
    access(32'h80, 4'b0000, 0, h, r);
    check("c28_ram", ram[8][31:0], 32'h1B2D3F42);
    check("c28_ram_hi", ram[8][63:32], 32'h44);
    access(32'h40, 4'b0000, 0, h, r);
    check("c28_data", r, 32'h1B2D3F42);

    // Reset asserted in the middle of a fill.
    apply_reset();
    @(negedge clk);
    enable = 1'b1; address = 32'h10; write_enable = 4'b0000;
    @(posedge clk); #1;
    enable = 1'b0;
    n = 0;
    while (!br_cmd_en && n < 50) begin @(posedge clk); #1; n++; end
    check("c29_cmd_seen", br_cmd_en, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("c29_busy", busy, 0);
    check("c29_cmd_en", br_cmd_en, 0);
    check("c29_ready", data_out_ready, 0);
    repeat (2) @(negedge clk);
    check("c29_cmd_en_hold", br_cmd_en, 0);
    rst_n = 1'b1;
    model_reset();
    access(32'h10, 4'b0000, 0, h, r);
    check("c29_miss", h, 0);
    check("c29_data", r, 32'h10);

    for (int t = 0; t < 300; t++) begin
      logic [31:0] a;
      logic [3:0]  we;
      a  = 32'($urandom_range(0, NWORD - 1) * 4);
      we = ($urandom_range(0, 9) < 4) ? 4'($urandom_range(1, 15)) : 4'b0000;
      access(a, we, $urandom, h, r);
    end
`ifdef CACHE_ASSOC_STATS_EN
    check("stat_hit_end", hit_count, nh);
    check("stat_miss_end", miss_count, nm);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
